div_64bit_seq: RTL and testbench
================================

// Module: div_64bit_seq
// PURPOSE
//  Multi-cycle 64-bit integer divider. It is the inverse companion of the combinational
//  64-bit signed multiplier in the eBPF ALU datapath, and serves the DIV and MOD opcodes.
//  Radix-2 restoring algorithm: one quotient bit per clock.
//  Valid/ready handshake on both sides, so the ALU issue logic can stall on it.
//  Handles signed and unsigned operands, divide-by-zero and signed overflow deterministically.
// PARAMETERS
//  WIDTH  64  operand/result width in bits (iteration count = WIDTH)
// PORTS
//  clk           in   1      single clock, all logic rising-edge
//  rst_n         in   1      asynchronous active-low reset
//  in_valid      in   1      operands and mode valid
//  in_ready      out  1      divider can accept (high only in IDLE)
//  a             in   WIDTH  dividend
//  b             in   WIDTH  divisor
//  is_signed     in   1      1: two's-complement operands; 0: unsigned
//  out_valid     out  1      results valid; held until accepted
//  out_ready     in   1      consumer accepts results
//  quotient      out  WIDTH  a / b, truncated toward zero
//  remainder     out  WIDTH  a % b, same sign as a (signed mode)
//  div_by_zero   out  1      set with out_valid when b == 0
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_by_zero=0;
//   iteration counter=0. Asserting reset mid-operation aborts the operation; no result is produced.
//  FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
//  IDLE
//   - in_ready=1.
//   - On in_valid&&in_ready, latch operands and sign flags. In signed mode, take |a| and |b|.
//   - If b==0, go to DONE directly with quotient=0, remainder=a, div_by_zero=1.
//     (eBPF semantics: x/0=0, x%0=x.)
//   - Otherwise go to CALC with counter=WIDTH-1 and partial remainder=0.
//  CALC (WIDTH cycles)
//   - Shift {rem, dividend} left by 1 and trial-subtract |b| from the WIDTH+1-bit rem.
//   - If non-negative, keep the difference and set q bit=1.
//   - Leave CALC when counter==0; otherwise decrement the counter.
//  FIX (1 cycle)
//   - Signed mode: negate q if sign(a)^sign(b); negate rem if sign(a).
//   - Register quotient/remainder; go to DONE.
//  DONE
//   - out_valid=1; outputs stable while out_valid&&!out_ready.
//   - On out_ready, go to IDLE with out_valid=0. in_ready rises the cycle after.
//     There is no accept in the same cycle as the output is taken.
//  Latency, accept edge to out_valid high:
//   - Normal: WIDTH+2 edges (=66 for WIDTH=64).
//   - b==0: 1 edge.
//  Throughput: one operation in flight. Inputs are ignored outside IDLE.
//  Width rules
//   - |MIN| is computed as an unsigned WIDTH-bit value; no extra bit is needed for magnitudes.
//   - Signed MIN / -1 wraps: quotient=MIN, remainder=0, div_by_zero=0.
//   - Unsigned mode never negates.
//  a==0: quotient=0, remainder=0 after the normal latency.
//  Internal state is not visible beyond the ports. quotient/remainder/div_by_zero keep
//   their last values after handshake until the next result.
// TESTING
//  1. Signed: a=24, b=6 -> q=4, r=0, dbz=0; out_valid exactly 66 cycles after accept.
//  2. Signed: a=-7, b=2 -> q=-3, r=-1. a=7, b=-2 -> q=-3, r=1. Unsigned: a=64'hFFFF_FFFF_FFFF_FFFF, b=2 -> q=64'h7FFF_FFFF_FFFF_FFFF, r=1.
//  3. Boundaries: MIN/-1 signed -> q=MIN, r=0. MAX/MAX -> q=1, r=0. MIN/MAX -> q=-1, r=-1. 0/5 -> q=0, r=0.
//  4. Divide by zero: a=123, b=0 (both modes) -> q=0, r=123, dbz=1, out_valid 1 cycle after accept.
//  5. Backpressure: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0. New in_valid during CALC/DONE is ignored; the next result matches the first operands.
//  6. Reset: assert rst_n=0 at cycle 30 of CALC -> out_valid=0, in_ready=1 immediately. Next op 100/7 -> q=14, r=2.

Source files
------------

// File: rtl/div_64bit_seq.sv
// Multi-cycle radix-2 restoring divider for eBPF DIV/MOD, signed or unsigned.
// Valid/ready on both sides; divide-by-zero gives q=0, r=a and completes in one cycle.
module div_64bit_seq #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  dvd_q, dvd_d;
    logic [WIDTH-1:0]  dsr_q, dsr_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  remo_q, remo_d;
    logic              dbz_q, dbz_d;

    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    shifted, trial;
    logic              b_zero;

    // Magnitudes stay WIDTH bits: |MIN| reads correctly as an unsigned value.
    always_comb begin
        a_neg   = is_signed & a[WIDTH-1];
        b_neg   = is_signed & b[WIDTH-1];
        a_mag   = a_neg ? (~a + 1'b1) : a;
        b_mag   = b_neg ? (~b + 1'b1) : b;
        b_zero  = (b == '0);
        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dsr_q};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = b_zero ? StDone : StCalc;
            StCalc: if (cnt_q == '0) state_d = StFix;
            StFix:  state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    // Datapath next-state
    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        negq_d = negq_q;
        negr_d = negr_q;
        quot_d = quot_q;
        remo_d = remo_q;
        dbz_d  = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    cnt_d  = CntW'(WIDTH - 1);
                    rem_d  = '0;
                    dvd_d  = a_mag;
                    dsr_d  = b_mag;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    if (b_zero) begin
                        quot_d = '0;
                        remo_d = a;
                        dbz_d  = 1'b1;
                    end
                end
            end
            StCalc: begin
                // Quotient bits shift into the freed low end of the dividend register.
                rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
            end
            StFix: begin
                quot_d = negq_q ? (~dvd_q + 1'b1) : dvd_q;
                remo_d = negr_q ? (~rem_q + 1'b1) : rem_q;
                dbz_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            dvd_q  <= '0;
            dsr_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            quot_q <= '0;
            remo_q <= '0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            quot_q <= quot_d;
            remo_q <= remo_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_64bit_seq.sv
// Directed bench for div_64bit_seq: results, latency, backpressure and mid-operation reset.
module tb_div_64bit_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] Min = 64'h8000_0000_0000_0000;
    localparam logic [63:0] Max = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] All = 64'hFFFF_FFFF_FFFF_FFFF;

    div_64bit_seq #(.WIDTH(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation at a negedge, count edges to out_valid, check, then hand off.
    task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                          input logic ts, input logic [63:0] eq, input logic [63:0] er,
                          input logic edbz, input int lat);
        int n;
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        is_signed = ts;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'(lat));
        check({tag, ".q"}, quotient, eq);
        check({tag, ".r"}, remainder, er);
        check({tag, ".dbz"}, 64'(div_by_zero), 64'(edbz));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".ov_drop"}, 64'(out_valid), 64'd0);
        check({tag, ".q_hold"}, quotient, eq);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.q", quotient, 64'd0);
        check("rst.r", remainder, 64'd0);
        check("rst.dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;

        run_op("s24_6",   64'd24,   64'd6,    1'b1, 64'd4,    64'd0,   1'b0, 66);
        run_op("sm7_2",   -64'sd7,  64'd2,    1'b1, -64'sd3,  -64'sd1, 1'b0, 66);
        run_op("s7_m2",   64'd7,    -64'sd2,  1'b1, -64'sd3,  64'd1,   1'b0, 66);
        run_op("uall_2",  All,      64'd2,    1'b0, Max,      64'd1,   1'b0, 66);
        run_op("umin_3",  Min,      64'd3,    1'b0, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0, 66);
        run_op("smin_m1", Min,      All,      1'b1, Min,      64'd0,   1'b0, 66);
        run_op("smax_max", Max,     Max,      1'b1, 64'd1,    64'd0,   1'b0, 66);
        run_op("smin_max", Min,     Max,      1'b1, All,      All,     1'b0, 66);
        run_op("s0_5",    64'd0,    64'd5,    1'b1, 64'd0,    64'd0,   1'b0, 66);
        run_op("s123_0",  64'd123,  64'd0,    1'b1, 64'd0,    64'd123, 1'b1, 1);
        run_op("u123_0",  64'd123,  64'd0,    1'b0, 64'd0,    64'd123, 1'b1, 1);
        run_op("sm5_0",   -64'sd5,  64'd0,    1'b1, 64'd0,    -64'sd5, 1'b1, 1);

        // Backpressure with stray in_valid during CALC and DONE.
        @(negedge clk);
        in_valid  = 1'b1;
        a         = 64'd1000;
        b         = 64'd3;
        is_signed = 1'b1;
        @(negedge clk);
        a = 64'd5;
        b = 64'd1;
        n = 1;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp.latency", 64'(n), 64'd66);
        repeat (10) begin
            @(negedge clk);
            check("bp.ov", 64'(out_valid), 64'd1);
            check("bp.in_ready", 64'(in_ready), 64'd0);
            check("bp.q", quotient, 64'd333);
            check("bp.r", remainder, 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp.ov_drop", 64'(out_valid), 64'd0);
        check("bp.in_ready_back", 64'(in_ready), 64'd1);

        // Reset mid-CALC aborts the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 64'd1000;
        b        = 64'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("rstmid.busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rstmid.ov", 64'(out_valid), 64'd0);
        check("rstmid.in_ready", 64'(in_ready), 64'd1);
        check("rstmid.q", quotient, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("rstmid.no_result", 64'(out_valid), 64'd0);
        run_op("s100_7", 64'd100, 64'd7, 1'b1, 64'd14, 64'd2, 1'b0, 66);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
